// File: rtl/onchip_stream_reader.sv
// onchip_stream_reader
//
// Avalon-MM read master for the single-port on-chip RAM (s1). It fetches
// `length` consecutive words starting at `base_addr` and delivers them in
// address order on a valid/ready stream toward the image-filter datapath.
// The block never writes memory.
//
// Optional feature: define ONCHIP_READER_CHECKSUM_EN to build a running
// modulo-2^DATA_W sum of every word transferred on the stream. Without the
// macro, `checksum` is tied to zero and no adder is built.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start                    one-cycle request, honoured only while idle
//   base_addr, length        run description, latched on an accepted start
//   busy, done               run in progress / one-cycle completion pulse
//   address, chipselect      RAM read request (one word per select cycle)
//   write, writedata,
//   byteenable, clken        RAM controls tied to read-only constants
//   readdata                 RAM data, valid the cycle after the address
//   out_data, out_valid,
//   out_ready                output stream
//   checksum                 sum of transferred words (optional feature)
module onchip_stream_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [3:0]        byteenable,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] checksum
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued;
    logic              rd_vld_p1;   // a read issued last cycle returns data now

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic start_ok;
    logic credit;
    logic issue;
    logic last_issue;
    logic push;
    logic pop;
    logic drained;

    assign write      = 1'b0;
    assign writedata  = '0;
    assign byteenable = 4'hF;
    assign clken      = 1'b1;

    assign start_ok   = (state == IDLE) && start;
    // Reserve a FIFO slot for every read still in flight so returning data
    // always has somewhere to land.
    assign credit     = (fifo_count + CNT_W'(rd_vld_p1)) < CNT_W'(FIFO_DEPTH);
    assign issue      = (state == ISSUE) && credit;
    assign last_issue = issue && (issued == (len_q - (ADDR_W+1)'(1)));
    assign push       = rd_vld_p1;
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    // Leave DRAIN in the same cycle the final word is taken, so done lands
    // directly after the last transfer.
    assign drained    = !rd_vld_p1 &&
                        ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    assign out_data   = out_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length == '0) ? FINISH : ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        chipselect = 1'b0;
        address    = '0;
        case (state)
            ISSUE: begin
                busy       = 1'b1;
                chipselect = issue;
                // Word address wraps naturally at the top of the RAM.
                if (issue) address = base_q + issued[ADDR_W-1:0];
            end
            DRAIN:   busy = 1'b1;
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued     <= '0;
            rd_vld_p1  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (start_ok) begin
                base_q <= base_addr;
                len_q  <= length;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + (ADDR_W+1)'(1);
            end
            rd_vld_p1 <= issue;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---- stage p1 -> FIFO: capture RAM data one cycle after the address ----
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= readdata;
    end

`ifdef ONCHIP_READER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      sum_q <= '0;
        else if (start_ok) sum_q <= '0;
        else if (pop)      sum_q <= sum_q + out_data;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule
